// File: rtl/llsc_mem_responder.sv
// llsc_mem_responder: shared-memory model for two cores with LL/SC support.
//
// Each port owns a one-entry pending slot. A single FSM (IDLE -> BUSY -> RESP)
// services one slot at a time with round-robin arbitration. The access is
// performed at the clock edge that ends the last BUSY cycle, so the response
// pulse appears LATENCY+2 cycles after an uncontended request.
//
// Parameters:
//   DEPTH_WORDS  backing store size in 32-bit words (power of two)
//   LATENCY      BUSY cycles per access (>= 1)
//   INIT_FILE    optional memory image name; the store starts zeroed
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   reqN_valid/wr/addr/wdata/atomic  request from core N (N = 0, 1)
//   respN_valid/rdata/sc_success     one-cycle response to core N
//   protocol_err                 sticky: request arrived at a busy port
//   sc_fail_cnt0/1               failed-SC counters
// Build option:
//   LLSC_SC_FAIL_CNT_EN  enables the saturating SC failure counters;
//                        when undefined the counter outputs are tied to 0.

module llsc_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_wr,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic        req0_atomic,
    input  logic        req1_valid,
    input  logic        req1_wr,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic        req1_atomic,
    output logic        resp0_valid,
    output logic [31:0] resp0_rdata,
    output logic        resp0_sc_success,
    output logic        resp1_valid,
    output logic [31:0] resp1_rdata,
    output logic        resp1_sc_success,
    output logic        protocol_err,
    output logic [15:0] sc_fail_cnt0,
    output logic [15:0] sc_fail_cnt1
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    // Port-indexed views of the request inputs
    logic [1:0]       req_valid;
    logic [1:0]       req_wr;
    logic [1:0]       req_atomic;
    logic [IDX_W-1:0] req_idx   [2];
    logic [31:0]      req_wdata [2];

    assign req_valid  = {req1_valid, req0_valid};
    assign req_wr     = {req1_wr, req0_wr};
    assign req_atomic = {req1_atomic, req0_atomic};
    assign req_idx[0] = req0_addr[2 +: IDX_W];
    assign req_idx[1] = req1_addr[2 +: IDX_W];
    assign req_wdata[0] = req0_wdata;
    assign req_wdata[1] = req1_wdata;

    // Address bits outside the word index are ignored by design
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req0_addr[31:IDX_W+2], req0_addr[1:0],
                                req1_addr[31:IDX_W+2], req1_addr[1:0]};

    // Pending slots
    logic [1:0]       slot_full_q;
    logic [1:0]       slot_wr_q;
    logic [1:0]       slot_atomic_q;
    logic [IDX_W-1:0] slot_idx_q   [2];
    logic [31:0]      slot_wdata_q [2];

    // Reservations
    logic [1:0]       resv_valid_q;
    logic [IDX_W-1:0] resv_idx_q [2];

    // FSM and datapath state
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_q, grant_d;
    logic             ptr_q, ptr_d;
    logic [31:0]      rdata_q;
    logic             sc_q;
    logic             perr_q;
    logic             do_access;
    logic             resp_fire;

    logic [31:0] mem [DEPTH_WORDS];

    // Memory starts zeroed; contents deliberately survive reset
    initial begin
        for (int i = 0; i < int'(DEPTH_WORDS); i++) mem[i] = '0;
    end

    // Granted request decode
    logic             other;
    logic [IDX_W-1:0] a_idx;
    logic             a_wr;
    logic             a_atomic;
    logic [31:0]      a_wdata;
    logic             sc_ok;
    logic             mem_we;

    assign other    = ~grant_q;
    assign a_idx    = slot_idx_q[grant_q];
    assign a_wr     = slot_wr_q[grant_q];
    assign a_atomic = slot_atomic_q[grant_q];
    assign a_wdata  = slot_wdata_q[grant_q];
    assign sc_ok    = resv_valid_q[grant_q] && (resv_idx_q[grant_q] == a_idx);
    assign mem_we   = do_access && a_wr && (!a_atomic || sc_ok);

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        do_access = 1'b0;
        resp_fire = 1'b0;
        case (state_q)
            StIdle: begin
                if (|slot_full_q) begin
                    // Pointer only matters when both ports are waiting
                    grant_d = (&slot_full_q) ? ptr_q : slot_full_q[1];
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    do_access = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                resp_fire = 1'b1;
                ptr_d     = other;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset gating keeps an uncommitted access from landing in memory
    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem[a_idx] <= a_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            grant_q       <= 1'b0;
            ptr_q         <= 1'b0;
            rdata_q       <= '0;
            sc_q          <= 1'b0;
            perr_q        <= 1'b0;
            slot_full_q   <= '0;
            slot_wr_q     <= '0;
            slot_atomic_q <= '0;
            resv_valid_q  <= '0;
            for (int n = 0; n < 2; n++) begin
                slot_idx_q[n]   <= '0;
                slot_wdata_q[n] <= '0;
                resv_idx_q[n]   <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;

            for (int n = 0; n < 2; n++) begin
                if (req_valid[n]) begin
                    // A full slot also covers the port currently in service
                    if (slot_full_q[n]) begin
                        perr_q <= 1'b1;
                    end else begin
                        slot_full_q[n]   <= 1'b1;
                        slot_wr_q[n]     <= req_wr[n];
                        slot_atomic_q[n] <= req_atomic[n];
                        slot_idx_q[n]    <= req_idx[n];
                        slot_wdata_q[n]  <= req_wdata[n];
                    end
                end
            end

            if (resp_fire) slot_full_q[grant_q] <= 1'b0;

            if (do_access) begin
                rdata_q <= a_wr ? 32'h0 : mem[a_idx];
                sc_q    <= a_wr && a_atomic && sc_ok;
                if (!a_wr && a_atomic) begin
                    resv_valid_q[grant_q] <= 1'b1;
                    resv_idx_q[grant_q]   <= a_idx;
                end else if (a_wr && !a_atomic) begin
                    for (int n = 0; n < 2; n++) begin
                        if (resv_idx_q[n] == a_idx) resv_valid_q[n] <= 1'b0;
                    end
                end else if (a_wr && a_atomic) begin
                    resv_valid_q[grant_q] <= 1'b0;
                    if (sc_ok && (resv_idx_q[other] == a_idx)) resv_valid_q[other] <= 1'b0;
                end
            end
        end
    end

    assign resp0_valid      = (state_q == StResp) && !grant_q;
    assign resp1_valid      = (state_q == StResp) && grant_q;
    assign resp0_rdata      = resp0_valid ? rdata_q : 32'h0;
    assign resp1_rdata      = resp1_valid ? rdata_q : 32'h0;
    assign resp0_sc_success = resp0_valid && sc_q;
    assign resp1_sc_success = resp1_valid && sc_q;
    assign protocol_err     = perr_q;

`ifdef LLSC_SC_FAIL_CNT_EN
    logic [15:0] fail_cnt_q [2];
    logic        sc_fail_resp;

    assign sc_fail_resp = resp_fire && a_wr && a_atomic && !sc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_cnt_q[0] <= '0;
            fail_cnt_q[1] <= '0;
        end else if (sc_fail_resp && (fail_cnt_q[grant_q] != 16'hFFFF)) begin
            fail_cnt_q[grant_q] <= fail_cnt_q[grant_q] + 16'd1;
        end
    end

    assign sc_fail_cnt0 = fail_cnt_q[0];
    assign sc_fail_cnt1 = fail_cnt_q[1];
`else
    assign sc_fail_cnt0 = 16'h0;
    assign sc_fail_cnt1 = 16'h0;
`endif

endmodule

// File: tb/tb_llsc_mem_responder.sv
// Self-checking bench for llsc_mem_responder (DEPTH_WORDS=1024, LATENCY=2).
// Table of sequential single-port transactions, hand-written multi-cycle
// sequences (arbitration, protocol error, reset mid-access) and a randomized
// two-port phase checked against a transaction-level memory/reservation model.

module tb_llsc_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam int          ULAT  = LAT + 2;       // uncontended latency
    localparam int          MAXLAT = 2 * LAT + 4;  // worst case behind the other port

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 0, req0_wr = 0, req0_atomic = 0;
    logic [31:0] req0_addr = 0, req0_wdata = 0;
    logic        req1_valid = 0, req1_wr = 0, req1_atomic = 0;
    logic [31:0] req1_addr = 0, req1_wdata = 0;
    logic        resp0_valid, resp0_sc_success, resp1_valid, resp1_sc_success;
    logic [31:0] resp0_rdata, resp1_rdata;
    logic        protocol_err;
    logic [15:0] sc_fail_cnt0, sc_fail_cnt1;

    llsc_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .INIT_FILE   ("")
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req0_valid       (req0_valid),
        .req0_wr          (req0_wr),
        .req0_addr        (req0_addr),
        .req0_wdata       (req0_wdata),
        .req0_atomic      (req0_atomic),
        .req1_valid       (req1_valid),
        .req1_wr          (req1_wr),
        .req1_addr        (req1_addr),
        .req1_wdata       (req1_wdata),
        .req1_atomic      (req1_atomic),
        .resp0_valid      (resp0_valid),
        .resp0_rdata      (resp0_rdata),
        .resp0_sc_success (resp0_sc_success),
        .resp1_valid      (resp1_valid),
        .resp1_rdata      (resp1_rdata),
        .resp1_sc_success (resp1_sc_success),
        .protocol_err     (protocol_err),
        .sc_fail_cnt0     (sc_fail_cnt0),
        .sc_fail_cnt1     (sc_fail_cnt1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        sc;
    } resp_t;

    resp_t rq0[$];
    resp_t rq1[$];

    // Last legal request per port, used by the reference model
    logic        pend_wr  [2];
    logic        pend_at  [2];
    logic [31:0] pend_addr[2];
    logic [31:0] pend_wd  [2];
    int          pend_cyc [2];

    // Transaction-level reference model
    bit          model_on = 0;
    logic [31:0] mm [DEPTH];
    bit          mrv [2];
    int          mri [2];
    int          mfail [2];

    task automatic model_check(input int p, input logic [31:0] rd, input logic sc);
        int          i;
        int          o;
        logic [31:0] exp_rd;
        logic        exp_sc;
        int          lat;
        i      = int'((pend_addr[p] >> 2) % DEPTH);
        o      = 1 - p;
        exp_rd = 32'h0;
        exp_sc = 1'b0;
        if (!pend_wr[p]) begin
            exp_rd = mm[i];
            if (pend_at[p]) begin
                mrv[p] = 1;
                mri[p] = i;
            end
        end else if (!pend_at[p]) begin
            mm[i] = pend_wd[p];
            for (int n = 0; n < 2; n++) if (mri[n] == i) mrv[n] = 0;
        end else begin
            if (mrv[p] && mri[p] == i) begin
                exp_sc = 1'b1;
                mm[i]  = pend_wd[p];
                if (mrv[o] && mri[o] == i) mrv[o] = 0;
            end else begin
                mfail[p]++;
            end
            mrv[p] = 0;
        end
        lat = cyc - pend_cyc[p];
        check($sformatf("rand_rdata_p%0d", p), rd, exp_rd);
        check($sformatf("rand_sc_p%0d", p), sc, exp_sc);
        check($sformatf("rand_lat_in_range_p%0d(lat=%0d)", p, lat),
              (lat >= ULAT && lat <= MAXLAT), 1);
    endtask

    // Response monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            check("resp_exclusive", resp0_valid & resp1_valid, 0);
            if (resp0_valid) begin
                rq0.push_back('{cyc, resp0_rdata, resp0_sc_success});
                if (model_on) model_check(0, resp0_rdata, resp0_sc_success);
            end else begin
                check("idle0_zero", {resp0_rdata, resp0_sc_success}, 0);
            end
            if (resp1_valid) begin
                rq1.push_back('{cyc, resp1_rdata, resp1_sc_success});
                if (model_on) model_check(1, resp1_rdata, resp1_sc_success);
            end else begin
                check("idle1_zero", {resp1_rdata, resp1_sc_success}, 0);
            end
        end
    end

    // Drive one request for one cycle; caller is at posedge+1
    task automatic issue(input int p, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic at, input bit legal,
                         output int icyc);
        icyc = cyc;
        if (legal) begin
            pend_wr[p]   = wr;
            pend_at[p]   = at;
            pend_addr[p] = addr;
            pend_wd[p]   = wdata;
            pend_cyc[p]  = cyc;
        end
        if (p == 0) begin
            req0_valid = 1; req0_wr = wr; req0_addr = addr; req0_wdata = wdata; req0_atomic = at;
        end else begin
            req1_valid = 1; req1_wr = wr; req1_addr = addr; req1_wdata = wdata; req1_atomic = at;
        end
        @(posedge clk);
        #1;
        if (p == 0) req0_valid = 0;
        else        req1_valid = 0;
    endtask

    task automatic wait_resp(input int p, output resp_t r, output bit ok);
        ok = 0;
        r  = '{0, 32'h0, 1'b0};
        for (int k = 0; k < 200; k++) begin
            if (p == 0 && rq0.size() > 0) begin
                r = rq0.pop_front(); ok = 1; break;
            end
            if (p == 1 && rq1.size() > 0) begin
                r = rq1.pop_front(); ok = 1; break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout_p%0d: got no response, expected one within 200 cycles", p);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        rq0.delete();
        rq1.delete();
    endtask

    typedef struct {
        int          port;
        logic        wr;
        logic        at;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_sc;
    } vec_t;

    vec_t tbl[$];

    task automatic rand_port(input int p, input int n);
        int          op;
        int          idx;
        logic [31:0] addr;
        int          ic;
        resp_t       r;
        bit          ok;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            op   = $urandom_range(0, 3);
            idx  = 512 + $urandom_range(0, 3);
            addr = (32'(idx) << 2) | (32'($urandom_range(0, 1)) << 12) | 32'($urandom_range(0, 3));
            issue(p, op >= 2, addr, $urandom, op == 1 || op == 3, 1, ic);
            wait_resp(p, r, ok);
        end
    endtask

    initial begin : main
        int    ic, ic0, ic1;
        resp_t r, r0, r1;
        bit    ok, ok0, ok1;
        int    efail [2];

        for (int i = 0; i < int'(DEPTH); i++) mm[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        rst = 0;

        // Reset state
        check("reset_perr", protocol_err, 0);
        check("reset_resp", {resp0_valid, resp1_valid}, 0);
        check("reset_cnt", {sc_fail_cnt0, sc_fail_cnt1}, 0);

        // port, wr, atomic, addr, wdata, exp rdata, exp sc
        tbl.push_back('{0, 1, 0, 32'h040,  32'hDEADBEEF, 32'h0,        0});
        tbl.push_back('{0, 0, 0, 32'h040,  32'h0,        32'hDEADBEEF, 0});
        tbl.push_back('{0, 0, 0, 32'h1042, 32'h0,        32'hDEADBEEF, 0}); // index wrap
        tbl.push_back('{1, 1, 0, 32'h080,  32'h5,        32'h0,        0});
        tbl.push_back('{1, 0, 1, 32'h080,  32'h0,        32'h5,        0});
        tbl.push_back('{1, 1, 1, 32'h080,  32'h6,        32'h0,        1});
        tbl.push_back('{1, 0, 0, 32'h080,  32'h0,        32'h6,        0});
        tbl.push_back('{1, 1, 1, 32'h080,  32'h7,        32'h0,        0}); // reservation consumed
        tbl.push_back('{1, 0, 0, 32'h080,  32'h0,        32'h6,        0});
        tbl.push_back('{0, 1, 0, 32'h100,  32'h11,       32'h0,        0});
        tbl.push_back('{0, 0, 1, 32'h100,  32'h0,        32'h11,       0});
        tbl.push_back('{1, 1, 0, 32'h100,  32'h22,       32'h0,        0}); // steal
        tbl.push_back('{0, 1, 1, 32'h100,  32'h33,       32'h0,        0});
        tbl.push_back('{0, 0, 0, 32'h100,  32'h0,        32'h22,       0});
        tbl.push_back('{0, 1, 0, 32'h200,  32'h1,        32'h0,        0});
        tbl.push_back('{0, 0, 1, 32'h200,  32'h0,        32'h1,        0});
        tbl.push_back('{1, 0, 1, 32'h200,  32'h0,        32'h1,        0});
        tbl.push_back('{0, 1, 1, 32'h200,  32'h2,        32'h0,        1});
        tbl.push_back('{1, 1, 1, 32'h200,  32'h3,        32'h0,        0}); // cleared by other SC
        tbl.push_back('{1, 0, 0, 32'h200,  32'h0,        32'h2,        0});
        tbl.push_back('{0, 0, 1, 32'h300,  32'h0,        32'h0,        0});
        tbl.push_back('{0, 0, 1, 32'h304,  32'h0,        32'h0,        0}); // LL overwrites
        tbl.push_back('{0, 1, 1, 32'h300,  32'h9,        32'h0,        0});
        tbl.push_back('{0, 0, 0, 32'h300,  32'h0,        32'h0,        0});
        tbl.push_back('{1, 0, 1, 32'h400,  32'h0,        32'h0,        0});
        tbl.push_back('{1, 0, 0, 32'h400,  32'h0,        32'h0,        0});
        tbl.push_back('{0, 0, 0, 32'h400,  32'h0,        32'h0,        0});
        tbl.push_back('{1, 1, 1, 32'h400,  32'hAB,       32'h0,        1}); // reads keep resv
        tbl.push_back('{1, 0, 0, 32'h400,  32'h0,        32'hAB,       0});

        efail[0] = 0;
        efail[1] = 0;
        foreach (tbl[i]) begin
            issue(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].at, 1, ic);
            wait_resp(tbl[i].port, r, ok);
            if (ok) begin
                check($sformatf("tbl%0d_rdata", i), r.rd, tbl[i].exp_rd);
                check($sformatf("tbl%0d_sc", i), r.sc, tbl[i].exp_sc);
                check($sformatf("tbl%0d_latency", i), r.cyc - ic, ULAT);
            end
            check($sformatf("tbl%0d_stray", i), rq0.size() + rq1.size(), 0);
            if (tbl[i].wr && tbl[i].at && !tbl[i].exp_sc) efail[tbl[i].port]++;
        end
`ifdef LLSC_SC_FAIL_CNT_EN
        check("tbl_fail_cnt0", sc_fail_cnt0, efail[0]);
        check("tbl_fail_cnt1", sc_fail_cnt1, efail[1]);
`else
        check("tbl_fail_cnt_off", {sc_fail_cnt0, sc_fail_cnt1}, 0);
`endif

        // Simultaneous requests after reset: port 0 first
        do_reset();
        check("rst_clears_cnt", {sc_fail_cnt0, sc_fail_cnt1}, 0);
        fork
            issue(0, 0, 32'h040, 0, 0, 1, ic0);
            issue(1, 0, 32'h080, 0, 0, 1, ic1);
        join
        wait_resp(0, r0, ok0);
        wait_resp(1, r1, ok1);
        if (ok0) check("sim_a_p0_lat", r0.cyc - ic0, ULAT);
        if (ok1) check("sim_a_p1_lat", r1.cyc - ic1, MAXLAT);
        if (ok0) check("sim_a_p0_rdata", r0.rd, 32'hDEADBEEF);
        if (ok1) check("sim_a_p1_rdata", r1.rd, 32'h6);
        // One lone port-0 access leaves the pointer on port 1
        issue(0, 0, 32'h040, 0, 0, 1, ic);
        wait_resp(0, r, ok);
        if (ok) check("sim_lone_lat", r.cyc - ic, ULAT);
        fork
            issue(0, 0, 32'h040, 0, 0, 1, ic0);
            issue(1, 0, 32'h080, 0, 0, 1, ic1);
        join
        wait_resp(1, r1, ok1);
        wait_resp(0, r0, ok0);
        if (ok1) check("sim_b_p1_lat", r1.cyc - ic1, ULAT);
        if (ok0) check("sim_b_p0_lat", r0.cyc - ic0, MAXLAT);

        // Protocol error: second request while the first is pending
        do_reset();
        check("perr_cleared", protocol_err, 0);
        issue(0, 0, 32'h080, 0, 0, 1, ic0);
        issue(0, 1, 32'h080, 32'h99, 0, 0, ic);
        check("perr_set", protocol_err, 1);
        wait_resp(0, r, ok);
        if (ok) begin
            check("perr_first_rdata", r.rd, 32'h6);
            check("perr_first_lat", r.cyc - ic0, ULAT);
        end
        repeat (20) @(posedge clk);
        #1;
        check("perr_no_second_resp", rq0.size() + rq1.size(), 0);
        check("perr_sticky", protocol_err, 1);
        issue(0, 0, 32'h080, 0, 0, 1, ic);
        wait_resp(0, r, ok);
        if (ok) check("perr_dropped_write", r.rd, 32'h6);
        check("perr_still_sticky", protocol_err, 1);

        // Reset in the last BUSY cycle: the write must not commit
        do_reset();
        issue(0, 1, 32'h040, 32'h12345678, 0, 1, ic);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        repeat (10) @(posedge clk);
        #1;
        check("rstmid_no_resp", rq0.size() + rq1.size(), 0);
        issue(0, 0, 32'h040, 0, 0, 1, ic);
        wait_resp(0, r, ok);
        if (ok) begin
            check("rstmid_mem_kept", r.rd, 32'hDEADBEEF);
            check("rstmid_lat", r.cyc - ic, ULAT);
        end

        // Randomized two-port traffic against the model (words 512..515 start at 0)
        do_reset();
        mrv[0] = 0; mrv[1] = 0; mri[0] = -1; mri[1] = -1;
        mfail[0] = 0; mfail[1] = 0;
        model_on = 1;
        fork
            rand_port(0, 60);
            rand_port(1, 60);
        join
        model_on = 0;
        repeat (4) @(posedge clk);
        #1;
`ifdef LLSC_SC_FAIL_CNT_EN
        check("rand_fail_cnt0", sc_fail_cnt0, mfail[0]);
        check("rand_fail_cnt1", sc_fail_cnt1, mfail[1]);
`else
        check("rand_fail_cnt_off", {sc_fail_cnt0, sc_fail_cnt1}, 0);
`endif
        check("rand_no_perr", protocol_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
